// File: rtl/alu_pkg.sv
// Purpose:      shared ALU constants: control codes, ALUOp classes, R-type funct fields, sequencer states.
// Latency:      n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    // ALU control codes as seen on the ALU's 4-bit control input
    localparam logic [3:0] CTRL_AND = 4'd0;
    localparam logic [3:0] CTRL_OR  = 4'd1;
    localparam logic [3:0] CTRL_ADD = 4'd2;
    localparam logic [3:0] CTRL_SUB = 4'd6;
    localparam logic [3:0] CTRL_SLT = 4'd7;
    localparam logic [3:0] CTRL_NOR = 4'd12;
    localparam logic [3:0] CTRL_ILL = 4'd15;

    // ALUOp operation classes; 6 and 7 are unassigned
    localparam logic [2:0] ALUOP_ADD   = 3'd0;
    localparam logic [2:0] ALUOP_SUB   = 3'd1;
    localparam logic [2:0] ALUOP_RTYPE = 3'd2;
    localparam logic [2:0] ALUOP_SLT   = 3'd3;
    localparam logic [2:0] ALUOP_AND   = 3'd4;
    localparam logic [2:0] ALUOP_OR    = 3'd5;

    // R-type funct fields honoured when ALUOp selects R-type
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // Issue sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Purpose:      bundles the issue handshake, the ALU drive/return bus and the result handshake.
// Latency:      n/a (wiring only).
// Backpressure: carries in_valid/in_ready and out_valid/out_ready pairs.
// Modports: slave  = the sequencer (alu_seq_ctrl) side,
//           master = the environment side (operation source, ALU, result sink).
interface alu_seq_ctrl_if #(
    parameter int DATA_W = 32
);
    // Operation issue handshake
    logic              in_valid_i;
    logic              in_ready_o;
    logic [2:0]        aluop_i;
    logic [5:0]        funct_i;
    logic [DATA_W-1:0] src1_i;
    logic [DATA_W-1:0] src2_i;

    // ALU drive and combinational return
    logic [DATA_W-1:0] alu_src1_o;
    logic [DATA_W-1:0] alu_src2_o;
    logic [3:0]        alu_ctrl_o;
    logic [DATA_W-1:0] alu_result_i;
    logic              alu_zero_i;

    // Result handshake
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] result_o;
    logic              zero_o;
    logic              illegal_o;

    modport slave (
        input  in_valid_i, aluop_i, funct_i, src1_i, src2_i,
        input  alu_result_i, alu_zero_i, out_ready_i,
        output in_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o,
        output out_valid_o, result_o, zero_o, illegal_o
    );

    modport master (
        output in_valid_i, aluop_i, funct_i, src1_i, src2_i,
        output alu_result_i, alu_zero_i, out_ready_i,
        input  in_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o,
        input  out_valid_o, result_o, zero_o, illegal_o
    );

endinterface

// File: rtl/alu_ctrl_dec.sv
// Purpose:      decodes ALUOp + funct into the ALU's 4-bit control code and an illegal flag.
// Latency:      purely combinational, zero cycles.
// Backpressure: none; no handshake.
// Ports: aluop (3b class), funct (6b R-type field) -> ctrl (4b code, 15 when illegal), illegal.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [2:0] aluop,
    input  logic [5:0] funct,
    output logic [3:0] ctrl,
    output logic       illegal
);

    always_comb begin
        // Anything not matched below is undecodable
        ctrl    = CTRL_ILL;
        illegal = 1'b1;
        case (aluop)
            ALUOP_ADD: begin ctrl = CTRL_ADD; illegal = 1'b0; end
            ALUOP_SUB: begin ctrl = CTRL_SUB; illegal = 1'b0; end
            ALUOP_SLT: begin ctrl = CTRL_SLT; illegal = 1'b0; end
            ALUOP_AND: begin ctrl = CTRL_AND; illegal = 1'b0; end
            ALUOP_OR:  begin ctrl = CTRL_OR;  illegal = 1'b0; end
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: begin ctrl = CTRL_ADD; illegal = 1'b0; end
                    FUNCT_SUB: begin ctrl = CTRL_SUB; illegal = 1'b0; end
                    FUNCT_AND: begin ctrl = CTRL_AND; illegal = 1'b0; end
                    FUNCT_OR:  begin ctrl = CTRL_OR;  illegal = 1'b0; end
                    FUNCT_NOR: begin ctrl = CTRL_NOR; illegal = 1'b0; end
                    FUNCT_SLT: begin ctrl = CTRL_SLT; illegal = 1'b0; end
                    default:   ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Purpose:      sequenced ALU issue controller: accept op, drive ALU for one EXEC cycle, hold result.
// Latency:      accept at edge N, result valid after edge N+1, earliest consume at edge N+2.
// Backpressure: out_ready low parks the result in DONE; no new op is accepted meanwhile.
// Ports: clk_i, rst_i (async active-low), bus (alu_seq_ctrl_if.slave: issue handshake,
//        ALU operand/ctrl drive + result/zero return, result handshake with result/zero/illegal).
// Build option ALU_SEQ_OVERLAP_EN: in DONE, in_ready follows out_ready so a new op can be
//        taken on the same edge the current result is consumed (one op per 2 cycles).
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    alu_seq_ctrl_if.slave bus
);

    state_t            state_q;
    state_t            state_d;
    logic              in_ready;
    logic              out_valid;
    logic              accept;

    logic [3:0]        dec_ctrl;
    logic              dec_ill;

    logic [DATA_W-1:0] src1_q;
    logic [DATA_W-1:0] src2_q;
    logic [3:0]        ctrl_q;
    logic              ill_pend_q;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;
    logic              illegal_q;

    alu_ctrl_dec u_dec (
        .aluop   (bus.aluop_i),
        .funct   (bus.funct_i),
        .ctrl    (dec_ctrl),
        .illegal (dec_ill)
    );

    assign accept = bus.in_valid_i && in_ready;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid_i) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
`ifdef ALU_SEQ_OVERLAP_EN
                // A new op can only enter when the held result leaves on the same edge
                in_ready = bus.out_ready_i;
                if (bus.out_ready_i) begin
                    state_d = bus.in_valid_i ? ST_EXEC : ST_IDLE;
                end
`else
                if (bus.out_ready_i) begin
                    state_d = ST_IDLE;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand/ctrl latch at the accepting edge; these registers drive the ALU directly
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            src1_q     <= '0;
            src2_q     <= '0;
            ctrl_q     <= '0;
            ill_pend_q <= 1'b0;
        end else if (accept) begin
            src1_q     <= bus.src1_i;
            src2_q     <= bus.src2_i;
            ctrl_q     <= dec_ctrl;
            ill_pend_q <= dec_ill;
        end
    end

    // Result capture at the end of EXEC. An illegal op ignores whatever the ALU
    // returns for code 15 and reports a clean zero result instead.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            result_q  <= ill_pend_q ? '0 : bus.alu_result_i;
            zero_q    <= ill_pend_q ? 1'b1 : bus.alu_zero_i;
            illegal_q <= ill_pend_q;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.alu_src1_o  = src1_q;
    assign bus.alu_src2_o  = src2_q;
    assign bus.alu_ctrl_o  = ctrl_q;
    assign bus.result_o    = result_q;
    assign bus.zero_o      = zero_q;
    assign bus.illegal_o   = illegal_q;

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequenced issue controller for the ALU. It sits on the ALU's driving side: accepts an operation (ALUOp + funct + operands) over a valid/ready handshake and decodes it into the ALU's 4-bit control code. It drives the combinational ALU for one execute cycle, captures result and zero, and presents them downstream over a second valid/ready handshake. It is the first step toward the multi-cycle datapath.

## Interface
Parameters:
- DATA_W, 32, operand/result width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- in_valid_i  in  1  operation offered
- in_ready_o  out  1  operation accepted when both high at rising edge
- aluop_i  in  3  operation class
- funct_i  in  6  R-type function field
- src1_i, src2_i  in  DATA_W  operands
- alu_src1_o, alu_src2_o  out  DATA_W  operands to ALU
- alu_ctrl_o  out  4  ALU control code
- alu_result_i  in  DATA_W  ALU result (combinational)
- alu_zero_i  in  1  ALU zero flag
- out_valid_o  out  1  result available
- out_ready_i  in  1  downstream accepts
- result_o  out  DATA_W  captured result
- zero_o  out  1  captured zero flag
- illegal_o  out  1  captured op was undecodable

## Operation
- ALUOp decode:
  - 0 → ADD (2)
  - 1 → SUB (6)
  - 2 → R-type via funct
  - 3 → SLT (7)
  - 4 → AND (0)
  - 5 → OR (1)
  - 6, 7 → illegal
- Funct decode when ALUOp=2:
  - 0x20 → 2
  - 0x22 → 6
  - 0x24 → 0
  - 0x25 → 1
  - 0x27 → NOR (12)
  - 0x2A → 7
  - other → illegal
- Illegal op: alu_ctrl_o=15. Captured result forced to 0, zero_o forced to 1, illegal_o=1, independent of the ALU response.
- FSM, three states:
  - IDLE: in_ready_o=1. Handshake latches operands, decoded ctrl and illegal flag → EXEC.
  - EXEC: latched operands and ctrl drive the ALU. At the cycle-end edge, capture alu_result_i/alu_zero_i into result_o/zero_o → DONE. Unconditional, one cycle.
  - DONE: out_valid_o=1. result_o/zero_o/illegal_o held stable until out_ready_i=1 at an edge → IDLE.
- ALU operand/ctrl outputs come from registers. Outside EXEC they hold their last value; they are not required to be zero.
- Inputs are sampled only at the accepting edge. Changes at any other time are ignored.
- Signed SLT semantics are owned by the ALU; this block passes operands unmodified.

## Timing
- Reset (async assert, sync-clean deassert), all outputs:
  - state=IDLE
  - in_ready_o=1, out_valid_o=0
  - result_o=0, zero_o=0, illegal_o=0
  - alu_src1_o=0, alu_src2_o=0, alu_ctrl_o=0
- Latency: accept at edge N. EXEC during cycle N..N+1. out_valid_o=1 after edge N+1. Earliest consume at edge N+2.
- Throughput without overlap: one op per 3 cycles minimum.
- Backpressure: out_ready_i low holds DONE indefinitely; in_ready_o stays 0 (except overlap case).
- in_valid_i with in_ready_o=0: no effect, op not consumed.
- Reset mid-EXEC or mid-DONE: pending op discarded, out_valid_o drops immediately (asynchronously), no output handshake occurs.
- in_ready_o and out_valid_o are never both 1, except in the overlap case.

## Configuration
- ALU_SEQ_OVERLAP_EN defined:
  - In DONE, in_ready_o = out_ready_i.
  - Simultaneous output and input handshakes at one edge → EXEC directly, skipping IDLE.
  - Sustained throughput one op per 2 cycles.
- Undefined:
  - in_ready_o=1 only in IDLE.
  - DONE always returns to IDLE.

## Structure
- Shared package alu_pkg holds:
  - ALU control code constants (AND=0, OR=1, ADD=2, SUB=6, SLT=7, NOR=12, ILL=15)
  - ALUOp constants
  - funct constants
  - the state enum
- One sub-module: alu_ctrl_dec, purely combinational (aluop, funct → ctrl, illegal). It is reusable by the single-cycle top.
- The ALU stays outside; the testbench connects it.

## Test plan
- Reset mid-EXEC (accept aluop=0 → EXEC, pulse rst_i low) → out_valid_o=0 immediately; state IDLE; in_ready_o=1; no output handshake.
- R-type SUB (aluop=2, funct=0x22, src1=5, src2=5, out_ready_i=1) → alu_ctrl_o=6 in EXEC; result_o=0, zero_o=1 at edge N+1; back in IDLE after edge N+2.
- SLT signed (aluop=3, src1=0xFFFFFFFF, src2=1) → result_o=1, zero_o=0, illegal_o=0.
- Illegal funct (aluop=2, funct=0x3F, src1=7, src2=9) → alu_ctrl_o=15, result_o=0, zero_o=1, illegal_o=1.
- Backpressure (NOR of 0,0, out_ready_i low 5 cycles, new in_valid_i offered meanwhile) → result_o=0xFFFFFFFF held; in_ready_o=0; second op not taken until release.
- Overlap build (two ADDs offered continuously, out_ready_i=1) → second accepted on the same edge the first is consumed; results 2 cycles apart. Without the macro: 3 cycles apart.
